einstein_kbd_matrix: RTL and testbench

PS/2 event to Einstein keyboard-matrix converter. It sits between the HPS keyboard feed (`ps2_key`) and the machine core, and holds an 8×8 key-state matrix plus the SHIFT, CTRL and GRAPH modifier flags. The core scans the matrix through active-low row selects, exactly as the PSG port A/B scan does on real hardware.

---
 rtl/einstein_kbd_pkg.sv | 35 +++
 rtl/einstein_kbd_decode.sv | 95 +++++++++
 rtl/einstein_kbd_matrix.sv | 88 ++++++++
 tb/tb_einstein_kbd_matrix.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/einstein_kbd_pkg.sv
// einstein_kbd_pkg: Einstein key matrix positions as {row,col}, modifier enum, decode result struct and panic code
package einstein_kbd_pkg;
  typedef enum logic [1:0] {MOD_NONE, MOD_SHIFT, MOD_CTRL, MOD_GRAPH} kbd_mod_e;
  typedef struct packed {
    logic     valid;
    logic     is_mod;
    kbd_mod_e mod;
    logic [2:0] row;
    logic [2:0] col;
  } kbd_dec_t;
  localparam logic [7:0] PANIC_CODE = 8'h07;
  localparam logic [7:0] RSHIFT_CODE = 8'h59;
  localparam logic [5:0] K_1 = 6'o00, K_2 = 6'o01, K_3 = 6'o02, K_4 = 6'o03;
  localparam logic [5:0] K_5 = 6'o04, K_6 = 6'o05, K_7 = 6'o06, K_8 = 6'o07;
  localparam logic [5:0] K_9 = 6'o10, K_0 = 6'o11, K_MINUS = 6'o12, K_EQ = 6'o13;
  localparam logic [5:0] K_BKSP = 6'o14, K_Q = 6'o15, K_W = 6'o16, K_E = 6'o17;
  localparam logic [5:0] K_R = 6'o20, K_T = 6'o21, K_Y = 6'o22, K_U = 6'o23;
  localparam logic [5:0] K_I = 6'o24, K_O = 6'o25, K_P = 6'o26, K_RET = 6'o27;
  localparam logic [5:0] K_ESC = 6'o30, K_A = 6'o31, K_S = 6'o32, K_D = 6'o33;
  localparam logic [5:0] K_F = 6'o34, K_G = 6'o35, K_H = 6'o36, K_J = 6'o37;
  localparam logic [5:0] K_K = 6'o40, K_L = 6'o41, K_SEMI = 6'o42, K_QUOTE = 6'o43;
  localparam logic [5:0] K_Z = 6'o44, K_X = 6'o45, K_C = 6'o46, K_V = 6'o47;
  localparam logic [5:0] K_B = 6'o50, K_N = 6'o51, K_M = 6'o52, K_COMMA = 6'o53;
  localparam logic [5:0] K_DOT = 6'o54, K_SLASH = 6'o55, K_SPACE = 6'o56, K_TAB = 6'o57;
  localparam logic [5:0] K_UP = 6'o60, K_DOWN = 6'o61, K_LEFT = 6'o62, K_RIGHT = 6'o63;
  localparam logic [5:0] K_F1 = 6'o64, K_F2 = 6'o65, K_F3 = 6'o66, K_F4 = 6'o67;
  localparam logic [5:0] K_LBRK = 6'o70, K_RBRK = 6'o71, K_BSLASH = 6'o72, K_F5 = 6'o73;
  localparam logic [5:0] K_F6 = 6'o74, K_F7 = 6'o75, K_F8 = 6'o76, K_CAPS = 6'o77;
  function automatic kbd_dec_t mk_key(input logic [5:0] p);
    return '{valid: 1'b1, is_mod: 1'b0, mod: MOD_NONE, row: p[5:3], col: p[2:0]};
  endfunction
  function automatic kbd_dec_t mk_mod(input kbd_mod_e m);
    return '{valid: 1'b1, is_mod: 1'b1, mod: m, row: 3'd0, col: 3'd0};
  endfunction
endpackage

// File: rtl/einstein_kbd_decode.sv
// einstein_kbd_decode: {ext,code} to matrix/modifier lookup; keypad and cursor aliases only with EINSTEIN_KBD_NUMPAD_EN
module einstein_kbd_decode
  import einstein_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output kbd_dec_t   dec
);
  always_comb begin
    dec = '0;
    case ({ext, code})
      9'h016: dec = mk_key(K_1);
      9'h01E: dec = mk_key(K_2);
      9'h026: dec = mk_key(K_3);
      9'h025: dec = mk_key(K_4);
      9'h02E: dec = mk_key(K_5);
      9'h036: dec = mk_key(K_6);
      9'h03D: dec = mk_key(K_7);
      9'h03E: dec = mk_key(K_8);
      9'h046: dec = mk_key(K_9);
      9'h045: dec = mk_key(K_0);
      9'h04E: dec = mk_key(K_MINUS);
      9'h055: dec = mk_key(K_EQ);
      9'h066: dec = mk_key(K_BKSP);
      9'h015: dec = mk_key(K_Q);
      9'h01D: dec = mk_key(K_W);
      9'h024: dec = mk_key(K_E);
      9'h02D: dec = mk_key(K_R);
      9'h02C: dec = mk_key(K_T);
      9'h035: dec = mk_key(K_Y);
      9'h03C: dec = mk_key(K_U);
      9'h043: dec = mk_key(K_I);
      9'h044: dec = mk_key(K_O);
      9'h04D: dec = mk_key(K_P);
      9'h05A: dec = mk_key(K_RET);
      9'h076: dec = mk_key(K_ESC);
      9'h01C: dec = mk_key(K_A);
      9'h01B: dec = mk_key(K_S);
      9'h023: dec = mk_key(K_D);
      9'h02B: dec = mk_key(K_F);
      9'h034: dec = mk_key(K_G);
      9'h033: dec = mk_key(K_H);
      9'h03B: dec = mk_key(K_J);
      9'h042: dec = mk_key(K_K);
      9'h04B: dec = mk_key(K_L);
      9'h04C: dec = mk_key(K_SEMI);
      9'h052: dec = mk_key(K_QUOTE);
      9'h01A: dec = mk_key(K_Z);
      9'h022: dec = mk_key(K_X);
      9'h021: dec = mk_key(K_C);
      9'h02A: dec = mk_key(K_V);
      9'h032: dec = mk_key(K_B);
      9'h031: dec = mk_key(K_N);
      9'h03A: dec = mk_key(K_M);
      9'h041: dec = mk_key(K_COMMA);
      9'h049: dec = mk_key(K_DOT);
      9'h04A: dec = mk_key(K_SLASH);
      9'h029: dec = mk_key(K_SPACE);
      9'h00D: dec = mk_key(K_TAB);
      9'h005: dec = mk_key(K_F1);
      9'h006: dec = mk_key(K_F2);
      9'h004: dec = mk_key(K_F3);
      9'h00C: dec = mk_key(K_F4);
      9'h054: dec = mk_key(K_LBRK);
      9'h05B: dec = mk_key(K_RBRK);
      9'h05D: dec = mk_key(K_BSLASH);
      9'h003: dec = mk_key(K_F5);
      9'h00B: dec = mk_key(K_F6);
      9'h083: dec = mk_key(K_F7);
      9'h00A: dec = mk_key(K_F8);
      9'h058: dec = mk_key(K_CAPS);
      9'h012, 9'h059: dec = mk_mod(MOD_SHIFT);
      9'h014, 9'h114: dec = mk_mod(MOD_CTRL);
      9'h011, 9'h111: dec = mk_mod(MOD_GRAPH);
`ifdef EINSTEIN_KBD_NUMPAD_EN
      9'h070: dec = mk_key(K_0);
      9'h069: dec = mk_key(K_1);
      9'h072: dec = mk_key(K_2);
      9'h07A: dec = mk_key(K_3);
      9'h06B: dec = mk_key(K_4);
      9'h073: dec = mk_key(K_5);
      9'h074: dec = mk_key(K_6);
      9'h06C: dec = mk_key(K_7);
      9'h075: dec = mk_key(K_8);
      9'h07D: dec = mk_key(K_9);
      9'h15A: dec = mk_key(K_RET);
      9'h175: dec = mk_key(K_UP);
      9'h172: dec = mk_key(K_DOWN);
      9'h16B: dec = mk_key(K_LEFT);
      9'h174: dec = mk_key(K_RIGHT);
`endif
      default: dec = '0;
    endcase
  end
endmodule

// File: rtl/einstein_kbd_matrix.sv
// einstein_kbd_matrix: PS/2 events to Einstein 8x8 key matrix plus SHIFT/CTRL/GRAPH, active-low row scan (keypad via EINSTEIN_KBD_NUMPAD_EN)
module einstein_kbd_matrix
  import einstein_kbd_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [10:0]     ps2_key,
  input  logic [ROWS-1:0] kb_row,
  output logic [COLS-1:0] kb_col,
  output logic            kb_shift,
  output logic            kb_ctrl,
  output logic            kb_graph,
  output logic            kb_down,
  output logic            evt_strobe
);
  kbd_dec_t dec;
  logic evt, apply, panic, rsel;
  logic tog_q;
  logic [ROWS-1:0][COLS-1:0] mat_q, mat_d;
  logic [1:0] shift_q, shift_d;
  logic ctrl_q, ctrl_d, graph_q, graph_d;
  logic [COLS-1:0] kb_col_q, kb_col_d;
  logic kb_shift_q, kb_shift_d, kb_ctrl_q, kb_ctrl_d, kb_graph_q, kb_graph_d;
  logic kb_down_q, kb_down_d, evt_strobe_q, evt_strobe_d;
  einstein_kbd_decode u_decode (
    .ext  (ps2_key[8]),
    .code (ps2_key[7:0]),
    .dec  (dec)
  );
  always_comb begin
    evt = ps2_key[10] != tog_q;
    apply = evt && dec.valid;
    panic = evt && ps2_key[9] && !ps2_key[8] && ps2_key[7:0] == PANIC_CODE;
    rsel = ps2_key[7:0] == RSHIFT_CODE;
    mat_d = mat_q;
    if (apply && !dec.is_mod) mat_d[dec.row][dec.col] = ps2_key[9];
    if (panic) mat_d = '0;
    shift_d = shift_q;
    if (apply && dec.is_mod && dec.mod == MOD_SHIFT) shift_d[rsel] = ps2_key[9];
    if (panic) shift_d = 2'b00;
    ctrl_d = panic ? 1'b0 : (apply && dec.is_mod && dec.mod == MOD_CTRL) ? ps2_key[9] : ctrl_q;
    graph_d = panic ? 1'b0 : (apply && dec.is_mod && dec.mod == MOD_GRAPH) ? ps2_key[9] : graph_q;
    evt_strobe_d = apply || panic;
    kb_col_d = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!kb_row[r] && mat_q[r][c]) kb_col_d[c] = 1'b0;
    kb_down_d = |mat_q;
    kb_shift_d = |shift_q;
    kb_ctrl_d = ctrl_q;
    kb_graph_d = graph_q;
  end
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (reset) begin
      mat_q <= '0;
      shift_q <= 2'b00;
      ctrl_q <= 1'b0;
      graph_q <= 1'b0;
      kb_col_q <= '1;
      kb_shift_q <= 1'b0;
      kb_ctrl_q <= 1'b0;
      kb_graph_q <= 1'b0;
      kb_down_q <= 1'b0;
      evt_strobe_q <= 1'b0;
    end else begin
      mat_q <= mat_d;
      shift_q <= shift_d;
      ctrl_q <= ctrl_d;
      graph_q <= graph_d;
      kb_col_q <= kb_col_d;
      kb_shift_q <= kb_shift_d;
      kb_ctrl_q <= kb_ctrl_d;
      kb_graph_q <= kb_graph_d;
      kb_down_q <= kb_down_d;
      evt_strobe_q <= evt_strobe_d;
    end
  end
  assign kb_col = kb_col_q;
  assign kb_shift = kb_shift_q;
  assign kb_ctrl = kb_ctrl_q;
  assign kb_graph = kb_graph_q;
  assign kb_down = kb_down_q;
  assign evt_strobe = evt_strobe_q;
endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// tb_einstein_kbd_matrix: directed checks of key matrix, modifiers, panic clear, reset and event timing
module tb_einstein_kbd_matrix;
  logic clk_sys = 1'b0;
  logic reset;
  logic [10:0] ps2_key;
  logic [7:0] kb_row;
  logic [7:0] kb_col;
  logic kb_shift, kb_ctrl, kb_graph, kb_down, evt_strobe;
  int checks = 0;
  int failures = 0;
  einstein_kbd_matrix dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .kb_row     (kb_row),
    .kb_col     (kb_col),
    .kb_shift   (kb_shift),
    .kb_ctrl    (kb_ctrl),
    .kb_graph   (kb_graph),
    .kb_down    (kb_down),
    .evt_strobe (evt_strobe)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask
  task automatic key(input string tag, input logic p, input logic e, input logic [7:0] code, input logic stb);
    ps2_key = {~ps2_key[10], p, e, code};
    tick();
    check({tag, "_stb"}, {7'd0, evt_strobe}, {7'd0, stb});
    tick();
  endtask
  initial begin
    reset = 1'b1;
    ps2_key = 11'h400;
    kb_row = 8'hFF;
    tick();
    tick();
    check("rst_col", kb_col, 8'hFF);
    check("rst_flags", {3'd0, kb_shift, kb_ctrl, kb_graph, kb_down, evt_strobe}, 8'h00);
    reset = 1'b0;
    tick();
    check("stale_tog", {7'd0, evt_strobe}, 8'h00);
    kb_row = 8'hF7;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    tick();
    check("a_stb", {7'd0, evt_strobe}, 8'h01);
    check("a_col_n1", kb_col, 8'hFF);
    tick();
    check("a_col", kb_col, 8'hFD);
    check("a_down", {7'd0, kb_down}, 8'h01);
    check("a_stb_off", {7'd0, evt_strobe}, 8'h00);
    key("a_rel", 1'b0, 1'b0, 8'h1C, 1'b1);
    check("a_rel_col", kb_col, 8'hFF);
    check("a_rel_down", {7'd0, kb_down}, 8'h00);
    key("a2", 1'b1, 1'b0, 8'h1C, 1'b1);
    key("one", 1'b1, 1'b0, 8'h16, 1'b1);
    check("r3_col", kb_col, 8'hFD);
    kb_row = 8'hF6;
    tick();
    check("r03_col", kb_col, 8'hFC);
    kb_row = 8'hFF;
    tick();
    check("nosel_col", kb_col, 8'hFF);
    kb_row = 8'hFE;
    tick();
    check("r0_col", kb_col, 8'hFE);
    key("a2_rel", 1'b0, 1'b0, 8'h1C, 1'b1);
    key("one_rel", 1'b0, 1'b0, 8'h16, 1'b1);
    key("lsh", 1'b1, 1'b0, 8'h12, 1'b1);
    check("lsh_shift", {7'd0, kb_shift}, 8'h01);
    key("rsh", 1'b1, 1'b0, 8'h59, 1'b1);
    check("rsh_shift", {7'd0, kb_shift}, 8'h01);
    key("lsh_rel", 1'b0, 1'b0, 8'h12, 1'b1);
    check("lsh_rel_shift", {7'd0, kb_shift}, 8'h01);
    check("sh_down", {7'd0, kb_down}, 8'h00);
    key("rsh_rel", 1'b0, 1'b0, 8'h59, 1'b1);
    check("rsh_rel_shift", {7'd0, kb_shift}, 8'h00);
    kb_row = 8'h00;
    key("p_a", 1'b1, 1'b0, 8'h1C, 1'b1);
    key("p_1", 1'b1, 1'b0, 8'h16, 1'b1);
    key("p_z", 1'b1, 1'b0, 8'h1A, 1'b1);
    key("p_ctrl", 1'b1, 1'b0, 8'h14, 1'b1);
    key("p_graph", 1'b1, 1'b1, 8'h11, 1'b1);
    key("p_shift", 1'b1, 1'b0, 8'h12, 1'b1);
    check("held_col", kb_col, 8'hEC);
    check("held_mods", {5'd0, kb_shift, kb_ctrl, kb_graph}, 8'h07);
    key("unmapped", 1'b1, 1'b0, 8'h0E, 1'b0);
    check("unmapped_col", kb_col, 8'hEC);
    check("unmapped_down", {7'd0, kb_down}, 8'h01);
    key("panic", 1'b1, 1'b0, 8'h07, 1'b1);
    check("panic_mods", {4'd0, kb_shift, kb_ctrl, kb_graph, kb_down}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      kb_row = ~(8'h01 << i);
      tick();
      check($sformatf("panic_col_r%0d", i), kb_col, 8'hFF);
    end
    kb_row = 8'hFE;
    key("pre_rst", 1'b1, 1'b0, 8'h16, 1'b1);
    check("pre_rst_col", kb_col, 8'hFE);
    reset = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1E};
    tick();
    check("mid_rst_col", kb_col, 8'hFF);
    reset = 1'b0;
    kb_row = 8'h00;
    tick();
    check("rst_evt_stb", {7'd0, evt_strobe}, 8'h00);
    tick();
    check("rst_evt_col", kb_col, 8'hFF);
    check("rst_evt_down", {7'd0, kb_down}, 8'h00);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h16};
    tick();
    check("b2b_stb0", {7'd0, evt_strobe}, 8'h01);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1E};
    tick();
    check("b2b_stb1", {7'd0, evt_strobe}, 8'h01);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h26};
    tick();
    check("b2b_stb2", {7'd0, evt_strobe}, 8'h01);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    tick();
    check("b2b_stb3", {7'd0, evt_strobe}, 8'h01);
    tick();
    check("b2b_stb_off", {7'd0, evt_strobe}, 8'h00);
    check("b2b_col", kb_col, 8'hF8);
    kb_row = 8'hF7;
    tick();
    check("b2b_col_r3", kb_col, 8'hFD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    kb_row = 8'hFE;
    tick();
`ifdef EINSTEIN_KBD_NUMPAD_EN
    key("kp1", 1'b1, 1'b0, 8'h69, 1'b1);
    check("kp1_col", kb_col, 8'hFE);
`else
    key("kp1", 1'b1, 1'b0, 8'h69, 1'b0);
    check("kp1_col", kb_col, 8'hFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
